prog_loader: RTL and testbench

- Boot-time sequencer that fills the program memory from a host byte stream, typically the UART receiver.
- Parses the framed stream, checks it, and drives the program memory write port (write, writeaddr, writevalue).
- Holds the CPU stopped until the image is loaded and verified.
- Sits between the UART receiver, the program memory and the CPU run/enable input.

---
 rtl/bali_loader_pkg.sv | 23 ++
 rtl/loader_timeout.sv | 31 +++
 rtl/prog_loader.sv | 158 +++++++++++++++
 tb/tb_prog_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bali_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The state enum is also exported on the loader's debug port.
package bali_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    LEN_HI = 3'd2,
    LEN_LO = 3'd3,
    DATA   = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hCA;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog: reloads on i_load and counts down while enabled.
// o_expired flags the cycle in which TIMEOUT idle cycles have elapsed.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_V = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  // Reload wins over the countdown so a byte arriving on the expiry cycle restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_V;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (TIMEOUT > 0) && i_en && (r_cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/DATA/XOR frames from a byte stream, writes
// program memory and releases the CPU only after a verified image.
module prog_loader
  import bali_loader_pkg::*;
#(
  parameter int unsigned SIZE      = 65536,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] load_count,
  output state_t      dbg_state
);

  localparam logic [16:0] SIZE17 = 17'(SIZE);

  state_t      r_state;
  logic [15:0] r_len;
  logic [7:0]  r_csum;
  logic        r_mem_write;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_data;
  logic        r_cpu_run;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic [15:0] r_load_count;

  logic        w_rx_ready;
  logic        w_accept;
  logic        w_timer_en;
  logic        w_expired;
  logic [15:0] w_len_next;
  logic        w_last;

  // Handshake: a byte transfers on every clock edge where rx_valid && rx_ready;
  // rx_ready depends only on the registered state, never on rx_valid.
  assign w_rx_ready = (r_state == SYNC) || (r_state == LEN_HI) || (r_state == LEN_LO) ||
                      (r_state == DATA) || (r_state == CHK);
  assign w_accept   = rx_valid && w_rx_ready;
  assign w_timer_en = w_rx_ready && (r_state != SYNC);
  assign w_len_next = {r_len[15:8], rx_data};
  assign w_last     = ({1'b0, r_load_count} + 17'd1) == {1'b0, r_len};

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept || !w_timer_en),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_csum       <= '0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_cpu_run    <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_load_count <= '0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= SYNC;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_load_count <= '0;
            r_csum       <= '0;
            r_cpu_run    <= 1'b0;
          end
        end
        SYNC: begin
          if (w_accept && (rx_data == SYNC_BYTE)) r_state <= LEN_HI;
        end
        default: begin
          if (w_accept) begin
            case (r_state)
              LEN_HI: begin
                r_len[15:8] <= rx_data;
                r_state     <= LEN_LO;
              end
              LEN_LO: begin
                r_len[7:0] <= rx_data;
                if ({1'b0, w_len_next} > SIZE17) begin
                  r_state    <= ERROR;
                  r_error    <= 1'b1;
                  r_err_code <= ERR_LEN;
                end else if (w_len_next == 16'd0) begin
                  r_state <= CHK;
                end else begin
                  r_state <= DATA;
                end
              end
              DATA: begin
                r_mem_write  <= 1'b1;
                r_mem_addr   <= r_load_count;
                r_mem_data   <= rx_data;
                r_load_count <= r_load_count + 16'd1;
                r_csum       <= r_csum ^ rx_data;
                if (w_last) r_state <= CHK;
              end
              CHK: begin
                if (rx_data == r_csum) begin
                  r_state   <= DONE;
                  r_done    <= 1'b1;
                  r_cpu_run <= 1'b1;
                end else begin
                  r_state    <= ERROR;
                  r_error    <= 1'b1;
                  r_err_code <= ERR_CSUM;
                end
              end
              default: ;
            endcase
          end else if (w_expired) begin
            r_state    <= ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end
      endcase
    end
  end

  assign rx_ready   = w_rx_ready;
  assign busy       = w_rx_ready;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign cpu_run    = r_cpu_run;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign load_count = r_load_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of framed streams, corner-case sequences and
// random frames checked against a frame-level reference parser.
module tb_prog_loader;
  import bali_loader_pkg::*;

  localparam int SIZE    = 16;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_write, cpu_run, busy, done, error;
  logic [15:0] mem_addr, load_count;
  logic [7:0]  mem_data;
  logic [1:0]  err_code;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [7:0]  b [0:23];
    int          n;
    logic        exp_done;
    logic [1:0]  exp_code;
    logic [15:0] exp_count;
  } vec_t;
  vec_t vecs [0:7];
  int   nv = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  prog_loader #(.SIZE(SIZE), .SYNC_BYTE(8'hCA), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_run(cpu_run), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .load_count(load_count), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: memory writes ----------------
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
      end else begin
        check("mem_write", {8'h00, mem_addr, mem_data}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_frame(input logic [7:0] b[$], output logic d, output logic [1:0] c,
                             output logic [15:0] cnt);
    int i = 0;
    int len;
    logic [7:0] x = 8'h00;
    while (i < b.size() && b[i] != 8'hCA) i++;
    len = {b[i+1], b[i+2]};
    if (len > SIZE) begin
      d = 1'b0; c = 2'd1; cnt = 16'd0;
      return;
    end
    for (int j = 0; j < len; j++) begin
      exp_q.push_back({16'(j), b[i+3+j]});
      x ^= b[i+3+j];
    end
    cnt = 16'(len);
    c   = (b[i+3+len] == x) ? 2'd0 : 2'd2;
    d   = (c == 2'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait: got 0 expected 1 for byte %0h", b);
      rx_valid = 1'b0;
      start    = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] q[$], input bit rand_timing);
    foreach (q[k])
      send_byte(q[k], rand_timing ? $urandom_range(0, 3) : 0,
                rand_timing && ($urandom_range(0, 4) == 0));
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] q[$], input bit rand_timing,
                           output logic d, output logic [1:0] c, output logic [15:0] cnt);
    model_frame(q, d, c, cnt);
    pulse_start();
    feed(q, rand_timing);
  endtask

  task automatic check_status(input string tag, input logic d, input logic [1:0] c,
                              input logic [15:0] cnt);
    check({tag, ".done"}, done, d);
    check({tag, ".error"}, error, (c != 2'd0));
    check({tag, ".err_code"}, err_code, c);
    check({tag, ".cpu_run"}, cpu_run, d);
    check({tag, ".load_count"}, load_count, cnt);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".writes_left"}, exp_q.size(), 0);
  endtask

  task automatic add_vec(input logic [7:0] q[$], input logic d, input logic [1:0] c,
                         input logic [15:0] cnt);
    foreach (q[k]) vecs[nv].b[k] = q[k];
    vecs[nv].n         = q.size();
    vecs[nv].exp_done  = d;
    vecs[nv].exp_code  = c;
    vecs[nv].exp_count = cnt;
    nv++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"}, dbg_state, IDLE);
    check({tag, ".rx_ready"}, rx_ready, 1'b0);
    check({tag, ".outs"}, {mem_write, cpu_run, busy, done, error, err_code}, 7'd0);
    check({tag, ".addr_data"}, {mem_addr, mem_data}, 24'd0);
    check({tag, ".load_count"}, load_count, 16'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    logic [7:0]  tq[$];
    logic        md;
    logic [1:0]  mc;
    logic [15:0] mcnt;
    bit          flag;

    tq = '{8'hCA, 8'h00, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
    add_vec(tq, 1'b1, 2'd0, 16'd3);
    tq = '{8'h00, 8'hFF, 8'hCA, 8'h00, 8'h01, 8'h5A, 8'h5A};
    add_vec(tq, 1'b1, 2'd0, 16'd1);
    tq = '{8'hCA, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00};
    add_vec(tq, 1'b0, 2'd2, 16'd2);
    tq = '{8'hCA, 8'h00, 8'h11};
    add_vec(tq, 1'b0, 2'd1, 16'd0);
    tq = '{8'hCA, 8'h00, 8'h00, 8'h00};
    add_vec(tq, 1'b1, 2'd0, 16'd0);
    tq = '{8'hCA, 8'h00, 8'h10};
    for (int k = 0; k < 16; k++) tq.push_back(8'(k));
    tq.push_back(8'h00);
    add_vec(tq, 1'b1, 2'd0, 16'd16);
    tq = '{8'hCA, 8'h00, 8'h00, 8'h5A};
    add_vec(tq, 1'b0, 2'd2, 16'd0);
    tq = '{8'hCA, 8'h01, 8'h00};
    add_vec(tq, 1'b0, 2'd1, 16'd0);

    // reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");

    // table-driven frames
    for (int v = 0; v < nv; v++) begin
      tq.delete();
      for (int k = 0; k < vecs[v].n; k++) tq.push_back(vecs[v].b[k]);
      run_frame(tq, 1'b0, md, mc, mcnt);
      check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_code, vecs[v].exp_count);
    end

    // start from DONE drops cpu_run on the next cycle
    tq = '{8'hCA, 8'h00, 8'h01, 8'h5A, 8'h5A};
    run_frame(tq, 1'b0, md, mc, mcnt);
    check("restart.done_before", done, 1'b1);
    model_frame(tq, md, mc, mcnt);
    pulse_start();
    check("restart.cpu_run", cpu_run, 1'b0);
    check("restart.busy", busy, 1'b1);
    check("restart.done", done, 1'b0);
    feed(tq, 1'b0);
    check_status("restart", 1'b1, 2'd0, 16'd1);

    // timeout after TIMEOUT idle cycles, then recovery
    pulse_start();
    exp_q.push_back({16'd0, 8'hAA});
    tq = '{8'hCA, 8'h00, 8'h04, 8'hAA};
    foreach (tq[k]) send_byte(tq[k], 0, 1'b0);
    flag = 1'b0;
    repeat (TIMEOUT) begin
      @(negedge clk);
      if (error) flag = 1'b1;
    end
    check("timeout.early", flag, 1'b0);
    @(negedge clk);
    check_status("timeout", 1'b0, 2'd3, 16'd1);
    tq = '{8'hCA, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30};
    run_frame(tq, 1'b0, md, mc, mcnt);
    check_status("recover", 1'b1, 2'd0, 16'd2);

    // byte accepted on the expiry cycle wins over the timeout
    tq = '{8'hCA, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h11};
    model_frame(tq, md, mc, mcnt);
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(tq[k], 0, 1'b0);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_byte(tq[4], 0, 1'b0);
    send_byte(tq[5], 0, 1'b0);
    @(negedge clk);
    check_status("expiry_race", 1'b1, 2'd0, 16'd2);

    // async reset mid-frame
    pulse_start();
    exp_q.push_back({16'd0, 8'h01});
    tq = '{8'hCA, 8'h00, 8'h05, 8'h01};
    foreach (tq[k]) send_byte(tq[k], 0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check("mid_reset.writes_left", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tq = '{8'hCA, 8'h00, 8'h01, 8'h77, 8'h77};
    run_frame(tq, 1'b0, md, mc, mcnt);
    check_status("after_reset", 1'b1, 2'd0, 16'd1);

    // randomized frames against the reference parser
    for (int r = 0; r < 30; r++) begin
      logic [7:0] x;
      int len;
      tq.delete();
      repeat ($urandom_range(0, 2)) begin
        x = 8'($urandom_range(0, 255));
        tq.push_back((x == 8'hCA) ? 8'h00 : x);
      end
      tq.push_back(8'hCA);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          tq.push_back(8'h00);
          tq.push_back(8'($urandom_range(SIZE + 1, 255)));
        end else begin
          tq.push_back(8'($urandom_range(1, 255)));
          tq.push_back(8'($urandom_range(0, 255)));
        end
      end else begin
        len = $urandom_range(0, SIZE);
        tq.push_back(8'h00);
        tq.push_back(8'(len));
        x = 8'h00;
        for (int k = 0; k < len; k++) begin
          tq.push_back(8'($urandom_range(0, 255)));
          x ^= tq[tq.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        tq.push_back(x);
      end
      run_frame(tq, 1'b1, md, mc, mcnt);
      check_status($sformatf("rand%0d", r), md, mc, mcnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
